// File: rtl/dmem_bus.sv
// Data memory for the core's MEM stage: one request at a time over valid/ready,
// byte/half/word accesses with extension, lane writes, fault flagging and a fixed response latency.
module dmem_bus #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
  localparam bit LAT_ONE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               accept_c;
  logic               finish_c;

  logic               we_q;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;

  logic [31:0]        mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] idx_c;
  logic               illegal_c, misalign_c, range_c, err_c;
  logic [31:0]        word_c, lane_c, load_c;
  logic [3:0]         be_c;
  logic [31:0]        wmask_c, wrep_c, wnew_c;

  // Power-up image; the array stores the XOR against it so an all-zero array reads as this image.
  function automatic logic [31:0] init_word(input logic [ADDR_WIDTH-1:0] i);
    if (i == ADDR_WIDTH'(0)) return 32'hDEAD_BEEF;
    if (i == ADDR_WIDTH'(1)) return 32'hCAFE_BABE;
    return 32'h0;
  endfunction

  assign req_ready = rst_n & ((state_q == IDLE) | (state_q == RESP));
  assign accept_c  = req_valid & req_ready;
  assign finish_c  = (state_q == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state: RESP is the cycle whose closing edge commits the access and registers the response.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_c) begin
          if (LAT_ONE) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = LAT_M1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept_c) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Access decode, load extraction and store merge for the captured request
  always_comb begin
    idx_c      = addr_q[ADDR_WIDTH+1:2];
    illegal_c  = (f3_q[1:0] == 2'b11) | (f3_q[2] & (we_q | f3_q[1]));
    misalign_c = ((f3_q[1:0] == 2'b01) & addr_q[0]) |
                 ((f3_q[1:0] == 2'b10) & (addr_q[1:0] != 2'b00));
    range_c    = ((addr_q >> (ADDR_WIDTH + 2)) != 32'h0);
    err_c      = illegal_c | misalign_c | range_c;

    word_c = mem_q[idx_c] ^ init_word(idx_c);
    lane_c = word_c >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b100:  load_c = {24'h0, lane_c[7:0]};
      3'b001:  load_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b101:  load_c = {16'h0, lane_c[15:0]};
      default: load_c = word_c;
    endcase

    case (f3_q[1:0])
      2'b00: begin
        be_c   = 4'b0001 << addr_q[1:0];
        wrep_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c   = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c   = 4'b1111;
        wrep_c = wdata_q;
      end
    endcase
    wmask_c = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
    wnew_c  = (word_c & ~wmask_c) | (wrep_c & wmask_c);
  end

  // Registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      resp_valid <= finish_c;
      resp_err   <= finish_c & err_c;
      resp_rdata <= (finish_c & ~err_c & ~we_q) ? load_c : 32'h0;
    end
  end

  // Array has no reset so stored data survives rst_n
  always_ff @(posedge clk) begin
    if (finish_c && we_q && !err_c) mem_q[idx_c] <= wnew_c ^ init_word(idx_c);
  end

endmodule

// File: tb/tb_dmem_bus.sv
// Bench for dmem_bus: three instances (LATENCY 2, 1, 4) checked against a byte-array model.
module tb_dmem_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vld [3];
  logic        we_i [3];
  logic [2:0]  f3_i [3];
  logic [31:0] addr_i [3];
  logic [31:0] wd_i [3];
  logic        rdy [3];
  logic        rv [3];
  logic        rerr [3];
  logic [31:0] rrd [3];

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] mb [3][1024];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      dmem_bus #(
        .ADDR_WIDTH(8),
        .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (vld[g]),
        .req_ready  (rdy[g]),
        .req_we     (we_i[g]),
        .req_funct3 (f3_i[g]),
        .req_addr   (addr_i[g]),
        .req_wdata  (wd_i[g]),
        .resp_valid (rv[g]),
        .resp_rdata (rrd[g]),
        .resp_err   (rerr[g])
      );
    end
  endgenerate

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  // Byte-addressed reference: legality, alignment, range, then little-endian byte moves.
  task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int n;
    int ai;
    logic legal;
    logic [31:0] v;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    er = !legal || ((a % 32'(n)) != 0) || (a >= 32'd1024);
    rd = 32'h0;
    if (!er) begin
      ai = int'(a[9:0]);
      if (we) begin
        for (int i = 0; i < n; i++) mb[d][ai + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[d][ai + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  // Drive one request, return response fields, edges to resp_valid (-1 on timeout) and ready in the cycle after accept.
  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic rdy_after);
    int waited;
    @(negedge clk);
    vld[d] = 1'b1; we_i[d] = we; f3_i[d] = f3; addr_i[d] = a; wd_i[d] = wd;
    waited = 0;
    while (!rdy[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1 vld[d] = 1'b0;
    rdy_after = rdy[d];
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (rv[d]) begin
        lat = k; rd = rrd[d]; er = rerr[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0; we_i[d] = 1'b0; f3_i[d] = 3'd0; addr_i[d] = 32'h0; wd_i[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({rdy[d], rv[d], rerr[d], rrd[d]} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", d, {rdy[d], rv[d], rerr[d], rrd[d]});
      end
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (rdy[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_after_reset dut%0d: got %b want 1", d, rdy[d]);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd, mrd;
    logic er, mer, ra;
    int lat;
    model_access(0, 1'b0, 3'd2, 32'h0, 32'h0, mrd, mer);
    do_req(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, er, lat, ra);
    n_cmp++;
    if (ra !== 1'b0) begin n_fail++; $display("FAIL ready_in_wait: got %b want 0", ra); end
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL latency2: got %0d want 2", lat); end
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF || rd !== mrd) begin
      n_fail++; $display("FAIL lw0_data: got %h want %h", rd, 32'hDEAD_BEEF);
    end
    n_cmp++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL lw0_err: got %b want 0", er); end
  endtask

  task automatic test_extension();
    logic [2:0]  f3_t  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] a_t   [4] = '{32'h7, 32'h7, 32'h2, 32'h2};
    logic [31:0] exp_t [4] = '{32'hFFFF_FFCA, 32'h0000_00CA, 32'hFFFF_DEAD, 32'h0000_DEAD};
    logic [31:0] rd, mrd;
    logic er, mer, ra;
    int lat;
    for (int i = 0; i < 4; i++) begin
      model_access(0, 1'b0, f3_t[i], a_t[i], 32'h0, mrd, mer);
      do_req(0, 1'b0, f3_t[i], a_t[i], 32'h0, rd, er, lat, ra);
      n_cmp++;
      if (rd !== exp_t[i] || er !== 1'b0 || lat !== 2) begin
        n_fail++;
        $display("FAIL extension_%0d: got rd=%h err=%b lat=%0d want rd=%h err=0 lat=2",
                 i, rd, er, lat, exp_t[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        we_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3_t [5] = '{3'd2, 3'd2, 3'd1, 3'd3, 3'd2};
    logic [31:0] a_t  [5] = '{32'h6, 32'h6, 32'h1, 32'h0, 32'h400};
    logic [31:0] rd, mrd, wd;
    logic er, mer, ra;
    int lat;
    for (int i = 0; i < 5; i++) begin
      wd = $urandom;
      model_access(0, we_t[i], f3_t[i], a_t[i], wd, mrd, mer);
      do_req(0, we_t[i], f3_t[i], a_t[i], wd, rd, er, lat, ra);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
        n_fail++;
        $display("FAIL error_%0d: got err=%b rd=%h lat=%0d want err=1 rd=0 lat=2", i, er, rd, lat);
      end
    end
    model_access(0, 1'b0, 3'd2, 32'h4, 32'h0, mrd, mer);
    do_req(0, 1'b0, 3'd2, 32'h4, 32'h0, rd, er, lat, ra);
    n_cmp++;
    if (rd !== 32'hCAFE_BABE || er !== 1'b0) begin
      n_fail++; $display("FAIL error_no_write: got %h want %h", rd, 32'hCAFE_BABE);
    end
  endtask

  task automatic test_lane_writes();
    logic        we_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t  [4] = '{3'd0, 3'd2, 3'd1, 3'd2};
    logic [31:0] a_t   [4] = '{32'h5, 32'h4, 32'h2, 32'h0};
    logic [31:0] wd_t  [4] = '{32'h0000_00AA, 32'h0, 32'h0000_1234, 32'h0};
    logic [31:0] exp_t [4] = '{32'h0, 32'hCAFE_AABE, 32'h0, 32'h1234_BEEF};
    logic [31:0] rd, mrd;
    logic er, mer, ra;
    int lat;
    for (int i = 0; i < 4; i++) begin
      model_access(0, we_t[i], f3_t[i], a_t[i], wd_t[i], mrd, mer);
      do_req(0, we_t[i], f3_t[i], a_t[i], wd_t[i], rd, er, lat, ra);
      n_cmp++;
      if (rd !== exp_t[i] || er !== 1'b0 || lat !== 2) begin
        n_fail++;
        $display("FAIL lane_%0d: got rd=%h err=%b lat=%0d want rd=%h err=0 lat=2",
                 i, rd, er, lat, exp_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        we_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3_t [4] = '{3'd2, 3'd2, 3'd0, 3'd2};
    logic [31:0] a_t  [4] = '{32'h8, 32'h8, 32'h9, 32'h8};
    logic [31:0] e_rd [4];
    logic        e_er [4];
    logic [31:0] bw;
    bw = $urandom;
    for (int i = 0; i < 4; i++) model_access(1, we_t[i], f3_t[i], a_t[i], bw, e_rd[i], e_er[i]);
    @(negedge clk);
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        vld[1] = 1'b1; we_i[1] = we_t[i]; f3_i[1] = f3_t[i]; addr_i[1] = a_t[i]; wd_i[1] = bw;
        n_cmp++;
        if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want 1", i, rdy[1]); end
      end else begin
        vld[1] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i > 0) begin
        n_cmp++;
        if (rv[1] !== 1'b1 || rrd[1] !== e_rd[i-1] || rerr[1] !== e_er[i-1]) begin
          n_fail++;
          $display("FAIL b2b_resp_%0d: got v=%b rd=%h err=%b want v=1 rd=%h err=%b",
                   i - 1, rv[1], rrd[1], rerr[1], e_rd[i-1], e_er[i-1]);
        end
        if (i == 2) begin
          n_cmp++;
          if (rrd[1] !== bw) begin n_fail++; $display("FAIL b2b_store_forward: got %h want %h", rrd[1], bw); end
        end
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (rv[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got %b want 0", rv[1]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, a, wd;
    logic er, mer, ra, we;
    logic [2:0] f3;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
        wd = $urandom;
        model_access(d, we, f3, a, wd, mrd, mer);
        do_req(d, we, f3, a, wd, rd, er, lat, ra);
        n_cmp++;
        if (rd !== mrd || er !== mer || lat !== lat_of(d)) begin
          n_fail++;
          $display("FAIL random dut%0d #%0d we=%b f3=%0d a=%h: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                   d, i, we, f3, a, rd, er, lat, mrd, mer, lat_of(d));
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd, mrd;
    logic er, mer, ra;
    int lat;
    @(negedge clk);
    vld[2] = 1'b1; we_i[2] = 1'b1; f3_i[2] = 3'd2; addr_i[2] = 32'h0; wd_i[2] = 32'h1111_1111;
    @(posedge clk);
    #1 vld[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy[2], rv[2], rerr[2], rrd[2]} !== 35'd0) begin
      n_fail++; $display("FAIL midop_reset_outputs: got %h want 0", {rdy[2], rv[2], rerr[2], rrd[2]});
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (rv[2] !== 1'b0) begin n_fail++; $display("FAIL midop_no_resp_in_reset: got %b want 0", rv[2]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (rv[2] !== 1'b0) begin n_fail++; $display("FAIL midop_no_resp_after: got %b want 0", rv[2]); end
    end
    model_access(2, 1'b0, 3'd2, 32'h0, 32'h0, mrd, mer);
    do_req(2, 1'b0, 3'd2, 32'h0, 32'h0, rd, er, lat, ra);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF || rd !== mrd || er !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL midop_store_dropped: got rd=%h err=%b lat=%0d want rd=%h err=0 lat=4",
               rd, er, lat, 32'hDEAD_BEEF);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 1024; i++) mb[d][i] = 8'h00;
      {mb[d][3], mb[d][2], mb[d][1], mb[d][0]} = 32'hDEAD_BEEF;
      {mb[d][7], mb[d][6], mb[d][5], mb[d][4]} = 32'hCAFE_BABE;
    end
    test_reset();
    test_latency();
    test_extension();
    test_errors();
    test_lane_writes();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_bus.md
# dmem_bus

Parametrised data memory for the RISC-V core, replacing the single-cycle word-only data memory. It accepts one load/store request at a time over a valid/ready handshake and supports RISC-V access sizes (byte, half, word) with sign/zero extension and byte-lane writes. It also flags misaligned, out-of-range and illegal-size accesses, and returns a registered response after a configurable latency. It sits between the core's MEM stage and the backing array, which is internal to this block.

## Interface

Parameters:

- `ADDR_WIDTH`, default 8: word-index bits; depth = 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 1: rising edges from request acceptance to `resp_valid` high. Legal range is 1..15.

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3 giving access size and signedness.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle pulse marking response.
- `resp_rdata` output 32: load result, extended; 0 for stores and errors.
- `resp_err` output 1: access faulted; qualifies `resp_valid`.

## Operation

- State machine: IDLE, WAIT, RESP.
- `req_ready` = 1 in IDLE and in RESP; 0 in WAIT and while `rst_n` is low.
- Accept: on an edge with `req_valid && req_ready`, capture we/funct3/addr/wdata.
  - If LATENCY = 1, go to RESP.
  - Otherwise go to WAIT with the counter loaded to LATENCY-1.
- WAIT: decrement the counter each edge; go to RESP on the edge where it reaches 0.
- RESP: `resp_valid` = 1 for exactly one cycle. Next state:
  - RESP if a new request is accepted in this cycle (LATENCY = 1);
  - WAIT if a new request is accepted and LATENCY > 1;
  - IDLE otherwise.
- Decoding of funct3:
  - 000 = byte, sign-extended (LB/SB).
  - 001 = half, sign-extended (LH/SH).
  - 010 = word (LW/SW).
  - 100 = byte, zero-extended (LBU).
  - 101 = half, zero-extended (LHU).
  - 011, 110 and 111 are illegal. Any store with funct3 100 or 101 is illegal.
- Byte lanes: lane k = bits [8k+7:8k], selected by addr[1:0]. Halves use lanes {addr[1]*2, addr[1]*2+1}.
- Error conditions (`resp_err` = 1, `resp_rdata` = 0, no memory write):
  - illegal funct3;
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - out of range: addr[31:ADDR_WIDTH+2] ≠ 0.
- Stores write only the selected lanes; unselected lanes keep their value.
- Array contents are not affected by reset. Initial contents: word 0 = 0xDEADBEEF, word 1 = 0xCAFEBABE, all other words 0.

## Timing

- Reset values of outputs: `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `req_ready` 0. Reset forces state to IDLE and the counter to 0.
- `req_ready` rises combinationally once `rst_n` is high and the state is IDLE.
- Latency: acceptance at edge E0 → `resp_valid`, `resp_rdata` and `resp_err` are registered and become valid after edge E0+LATENCY.
- Memory is written at the same edge E0+LATENCY. Load data is sampled from the array at that edge.
- Throughput: one request per LATENCY cycles.
  - Back-to-back acceptance in RESP is allowed.
  - A load following a store to the same word sees the stored data.
- `req_valid` with `req_ready` = 0 is ignored and does not need to be held by this block. The core holds it.
- Reset mid-operation: a pending request is discarded and a pending store is not committed. `resp_valid` is never produced for it.
- The response has no back-pressure. The core must consume the response in its `resp_valid` cycle.

## Test plan

- LATENCY=2, LW addr 0x0 → `resp_valid` 2 edges after accept; rdata 0xDEADBEEF, err 0. `req_ready` is 0 in the WAIT cycle.
- Sign/zero extension:
  - LB addr 0x7 → 0xFFFFFFCA.
  - LBU addr 0x7 → 0x000000CA.
  - LH addr 0x2 → 0xFFFFDEAD.
  - LHU addr 0x2 → 0x0000DEAD.
- Lane writes:
  - SB 0x000000AA to addr 0x5, then LW 0x4 → 0xCAFEAABE.
  - SH 0x1234 to addr 0x2, then LW 0x0 → 0x1234BEEF.
- Errors, each giving `resp_err` 1, rdata 0 and memory unchanged:
  - LW 0x6;
  - SW 0x6, then LW 0x4 → 0xCAFEBABE;
  - LH 0x1;
  - funct3 011;
  - addr 0x400 with ADDR_WIDTH=8.
- Back-to-back, LATENCY=1: `req_valid` held high for 4 consecutive requests (SW, LW, LB, LW). Check 4 consecutive `resp_valid` pulses and that the LW after the SW returns the stored value.
- Reset mid-operation, LATENCY=4: pull `rst_n` low 2 cycles after accepting SW 0x11111111 to addr 0x0.
  - All outputs 0 immediately; no `resp_valid` appears.
  - A subsequent LW 0x0 returns 0xDEADBEEF.
